prg_loader: RTL and testbench
=============================

Name: prg_loader

Overview:
- Sits between data_io and the SDRAM/VIC-20 memory write path.
- Converts a PRG or CRT byte stream into absolute memory writes, using either the 2-byte load-address header or a fixed $A000 base.
- When the download ends, writes the BASIC/KERNAL end-of-program pointers into zero page, then requests a machine reset if a cartridge was loaded at $A000.
- Replaces the ad-hoc address tracking and injection logic in the top level.

Parameters:
- INJ_SPACING, 2: cycles between consecutive injected writes; must be ≥2. The downstream memory path accepts a write within this many cycles.
- CART_BASE, 16'hA000: load address that marks a cartridge image and triggers the auto-reset.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- downloading  in  1  data_io download-active level.
- index  in  8  data_io file index. Zero means ROM; the block is active only when downloading=1 and index≠0.
- wr  in  1  data_io byte strobe, one clk_sys cycle wide.
- addr  in  16  byte offset within the file.
- dout  in  8  file byte.
- raw_mode  in  1  1 = file has no header; load at CART_BASE (status[2]).
- mem_addr  out  16  write address.
- mem_data  out  8  write data.
- mem_wr  out  1  one-cycle write strobe.
- busy  out  1  high in LOAD, INJECT or FINISH.
- force_reset  out  1  one-cycle reset request.

Behaviour:
- Reset values: all outputs 0, state IDLE, cur_addr=0, cart_flag=0, byte_cnt=0.
- States and transitions:
  - IDLE → LOAD when prg_active = downloading & (index≠0) is high.
  - LOAD → INJECT on the falling edge of prg_active, if byte_cnt ≥ 1; otherwise LOAD → IDLE.
  - INJECT → FINISH after the last table entry is written.
  - FINISH → IDLE after one cycle.
- LOAD with header (raw_mode=0):
  - wr at addr 0 latches cur_addr[7:0].
  - wr at addr 1 latches cur_addr[15:8].
  - Each wr at addr ≥2 issues a write: mem_addr=cur_addr, mem_data=dout, mem_wr=1 on the cycle after wr (latency 1). cur_addr then increments by 1, and byte_cnt saturates at 65535.
- LOAD with raw_mode=1: cur_addr is preset to CART_BASE on entry; every wr, including addr 0, writes and increments.
- cart_flag is set when the first data write has mem_addr==CART_BASE.
- Address arithmetic: 16-bit, wrapping ($FFFF+1 → $0000), no error.
- end_ptr is cur_addr when LOAD exits, i.e. one past the last byte written.
- INJECT table, in this order, one entry every INJ_SPACING cycles, mem_wr one cycle per entry:
  - $2D=lo, $2E=hi
  - $2F=lo, $30=hi
  - $31=lo, $32=hi
  - $AE=lo, $AF=hi
  - lo/hi are the bytes of end_ptr.
- FINISH: force_reset=cart_flag for exactly one cycle, then cart_flag clears.
- Simultaneous events:
  - If prg_active rises during INJECT or FINISH, the sequence aborts with no further writes and no force_reset, and the block enters LOAD with fresh header state.
  - A wr coincident with the falling edge of prg_active is still written.
- Reset in any state: immediate return to IDLE with reset values; a pending injection is discarded.
- ROM downloads (index=0) are ignored entirely: no mem_wr, state unchanged.

Optional Feature:
- Macro: PRG_AUTORUN_EN.
- When defined: after the $AF entry, INJECT appends five writes at the same spacing:
  - $0277=$52, $0278=$55, $0279=$4E, $027A=$0D ("RUN⏎")
  - then $C6=$04 (keyboard buffer count)
  - Skipped when cart_flag=1.
- When undefined: the table ends at $AF and the logic is absent.

Decomposition:
- Package prg_loader_pkg holds:
  - state enum (IDLE, LOAD, INJECT, FINISH)
  - zero-page pointer address constants
  - keyboard buffer constants ($0277, $C6, RUN bytes)
  - table length localparams with and without the feature
- Sub-module prg_inject_seq:
  - inputs: step index and end_ptr
  - outputs: {addr, data, last}
  - purely combinational table; the spacing counter and step counter stay in prg_loader.

Test Plan:
- Header file 01 10 AA BB CC, raw_mode=0 → writes $1001=AA, $1002=BB, $1003=CC. After the download ends: $2D/$2F/$31/$AE=$04 and $2E/$30/$32/$AF=$10, 8 strobes INJ_SPACING apart, force_reset stays 0.
- raw_mode=1, 4 bytes 11 22 33 44 → $A000..$A003 written. Pointers are lo=$04, hi=$A0. force_reset pulses exactly once, one cycle, after the $AF write.
- Header-only file (2 bytes) → no mem_wr at all, no force_reset, busy returns to 0 one cycle after downloading falls.
- Header FF FF, then 3 data bytes → writes $FFFF, $0000, $0001; end_ptr=$0002.
- reset asserted during INJECT after the $30 write → no further mem_wr, all outputs 0 the next cycle. A new download with index=0 produces no writes.
- With PRG_AUTORUN_EN and header load at $1001 → 13 injected writes, ending with $C6=$04. The same file loaded at $A000 gives 8 writes plus force_reset.

Source files
------------

// File: rtl/prg_loader_pkg.sv
// Shared types and constants for the PRG/CRT loader.
// PRG_AUTORUN_EN extends the injection table with a "RUN<CR>" keyboard-buffer stuff.
package prg_loader_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    INJECT = 2'd2,
    FINISH = 2'd3
  } state_t;

  // BASIC/KERNAL end-of-program pointers (each is lo at addr, hi at addr+1)
  localparam logic [15:0] ZP_VARTAB = 16'h002D;
  localparam logic [15:0] ZP_ARYTAB = 16'h002F;
  localparam logic [15:0] ZP_STREND = 16'h0031;
  localparam logic [15:0] ZP_EAL    = 16'h00AE;

  localparam logic [15:0] KB_BUF    = 16'h0277;
  localparam logic [15:0] KB_CNT    = 16'h00C6;
  localparam logic [7:0]  RUN_R     = 8'h52;
  localparam logic [7:0]  RUN_U     = 8'h55;
  localparam logic [7:0]  RUN_N     = 8'h4E;
  localparam logic [7:0]  RUN_CR    = 8'h0D;
  localparam logic [7:0]  RUN_LEN   = 8'h04;

  localparam int INJ_LEN_BASE    = 8;
  localparam int INJ_LEN_AUTORUN = 13;
`ifdef PRG_AUTORUN_EN
  localparam int INJ_LEN = INJ_LEN_AUTORUN;
`else
  localparam int INJ_LEN = INJ_LEN_BASE;
`endif
  localparam int STEP_W = 4;

endpackage

// File: rtl/prg_loader_inject_seq.sv
// Combinational table of post-load writes, indexed by step.
// Entries 8..12 exist only with PRG_AUTORUN_EN.
module prg_inject_seq
  import prg_loader_pkg::*;
(
  input  logic [STEP_W-1:0] step,
  input  logic [15:0]       end_ptr,
  output logic [15:0]       addr,
  output logic [7:0]        data,
  output logic              last
);

  always_comb begin
    addr = '0;
    data = '0;
    case (step)
      4'd0:  begin addr = ZP_VARTAB;         data = end_ptr[7:0];  end
      4'd1:  begin addr = ZP_VARTAB + 16'd1; data = end_ptr[15:8]; end
      4'd2:  begin addr = ZP_ARYTAB;         data = end_ptr[7:0];  end
      4'd3:  begin addr = ZP_ARYTAB + 16'd1; data = end_ptr[15:8]; end
      4'd4:  begin addr = ZP_STREND;         data = end_ptr[7:0];  end
      4'd5:  begin addr = ZP_STREND + 16'd1; data = end_ptr[15:8]; end
      4'd6:  begin addr = ZP_EAL;            data = end_ptr[7:0];  end
      4'd7:  begin addr = ZP_EAL + 16'd1;    data = end_ptr[15:8]; end
`ifdef PRG_AUTORUN_EN
      4'd8:  begin addr = KB_BUF;            data = RUN_R;   end
      4'd9:  begin addr = KB_BUF + 16'd1;    data = RUN_U;   end
      4'd10: begin addr = KB_BUF + 16'd2;    data = RUN_N;   end
      4'd11: begin addr = KB_BUF + 16'd3;    data = RUN_CR;  end
      4'd12: begin addr = KB_CNT;            data = RUN_LEN; end
`endif
      default: begin addr = '0; data = '0; end
    endcase
  end

  assign last = (step == STEP_W'(INJ_LEN - 1));

endmodule

// File: rtl/prg_loader.sv
// Turns a PRG/CRT download into absolute memory writes, then injects end pointers.
// Optional macro PRG_AUTORUN_EN appends an autorun keyboard-buffer sequence.
//
// state  | meaning
// IDLE   | waiting for a non-ROM download
// LOAD   | header capture and data writes
// INJECT | writing the pointer table, one entry per INJ_SPACING cycles
// FINISH | one-cycle cartridge reset request, then back to IDLE
module prg_loader
  import prg_loader_pkg::*;
#(
  parameter int          INJ_SPACING = 2,
  parameter logic [15:0] CART_BASE   = 16'hA000
)(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        downloading,
  input  logic [7:0]  index,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [7:0]  dout,
  input  logic        raw_mode,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_wr,
  output logic        busy,
  output logic        force_reset
);

  localparam int SP_W = $clog2(INJ_SPACING + 1);

  state_t              state_q, state_d;
  logic [15:0]         cur_q, cur_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                cart_q, cart_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic [15:0]         maddr_d;
  logic [7:0]          mdata_d;
  logic                mwr_d, force_d;
  logic                prg_active;
  logic [15:0]         tbl_addr;
  logic [7:0]          tbl_data;
  logic                tbl_last, inj_last;

  assign prg_active = downloading & (index != 8'd0);

  prg_inject_seq u_seq (
    .step    (step_q),
    .end_ptr (cur_q),
    .addr    (tbl_addr),
    .data    (tbl_data),
    .last    (tbl_last)
  );

`ifdef PRG_AUTORUN_EN
  // a cartridge starts itself, so it gets no RUN
  assign inj_last = tbl_last | (cart_q & (step_q == STEP_W'(INJ_LEN_BASE - 1)));
`else
  assign inj_last = tbl_last;
`endif

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    cart_d  = cart_q;
    step_d  = step_q;
    sp_d    = sp_q;
    maddr_d = '0;
    mdata_d = '0;
    mwr_d   = 1'b0;
    force_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (prg_active) begin
          state_d = LOAD;
          cur_d   = raw_mode ? CART_BASE : 16'h0000;
          cnt_d   = '0;
          cart_d  = 1'b0;
        end
      end
      LOAD: begin
        if (wr) begin
          if (raw_mode || addr >= 16'd2) begin
            mwr_d   = 1'b1;
            maddr_d = cur_q;
            mdata_d = dout;
            cur_d   = cur_q + 16'd1;
            cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
            if (cnt_q == 16'd0 && cur_q == CART_BASE) cart_d = 1'b1;
          end else if (addr == 16'd0) begin
            cur_d[7:0] = dout;
          end else begin
            cur_d[15:8] = dout;
          end
        end
        // a byte arriving with the falling edge is still counted above
        if (!prg_active) begin
          step_d  = '0;
          sp_d    = '0;
          state_d = (cnt_d != 16'd0) ? INJECT : IDLE;
        end
      end
      INJECT: begin
        if (prg_active) begin
          state_d = LOAD;
          cur_d   = raw_mode ? CART_BASE : 16'h0000;
          cnt_d   = '0;
          cart_d  = 1'b0;
        end else if (sp_q == '0) begin
          mwr_d   = 1'b1;
          maddr_d = tbl_addr;
          mdata_d = tbl_data;
          sp_d    = SP_W'(INJ_SPACING - 1);
          step_d  = step_q + 1'b1;
          if (inj_last) state_d = FINISH;
        end else begin
          sp_d = sp_q - 1'b1;
        end
      end
      FINISH: begin
        if (prg_active) begin
          state_d = LOAD;
          cur_d   = raw_mode ? CART_BASE : 16'h0000;
          cnt_d   = '0;
          cart_d  = 1'b0;
        end else begin
          force_d = cart_q;
          cart_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      cnt_q       <= '0;
      cart_q      <= 1'b0;
      step_q      <= '0;
      sp_q        <= '0;
      mem_addr    <= '0;
      mem_data    <= '0;
      mem_wr      <= 1'b0;
      force_reset <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      cnt_q       <= cnt_d;
      cart_q      <= cart_d;
      step_q      <= step_d;
      sp_q        <= sp_d;
      mem_addr    <= maddr_d;
      mem_data    <= mdata_d;
      mem_wr      <= mwr_d;
      force_reset <= force_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_prg_loader.sv
// Directed bench for prg_loader with a write-list model and per-cycle compare.
module tb_prg_loader;

  localparam int          SP   = 3;
  localparam logic [15:0] CART = 16'hA000;
`ifdef PRG_AUTORUN_EN
  localparam int INJ_FULL = 13;
`else
  localparam int INJ_FULL = 8;
`endif

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        downloading = 1'b0;
  logic [7:0]  index = 8'd0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  dout = '0;
  logic        raw_mode = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wr, busy, force_reset;

  prg_loader #(.INJ_SPACING(SP), .CART_BASE(CART)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .downloading (downloading),
    .index       (index),
    .wr          (wr),
    .addr        (addr),
    .dout        (dout),
    .raw_mode    (raw_mode),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_wr      (mem_wr),
    .busy        (busy),
    .force_reset (force_reset)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
    logic        inj;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] mem_obs [logic [15:0]];
  int         n_vec = 0, n_err = 0;
  int         force_cnt = 0, exp_force = 0;
  int         inj_seen = 0;
  int         cyc = 0, prev_cyc = 0;
  bit         prev_inj_ok = 0;

  // Expected write list from the file contents alone.
  task automatic build_model(input logic [7:0] b[$], input bit raw);
    logic [15:0] cur;
    logic [15:0] zp [4];
    int start, data_n;
    bit cart;
    zp[0] = 16'h002D; zp[1] = 16'h002F; zp[2] = 16'h0031; zp[3] = 16'h00AE;
    data_n = 0;
    cart = 0;
    if (raw) begin
      cur = CART; start = 0;
    end else begin
      cur = (b.size() >= 2) ? {b[1], b[0]} : 16'h0000;
      start = 2;
    end
    for (int i = start; i < b.size(); i++) begin
      if (data_n == 0 && cur == CART) cart = 1;
      exp_q.push_back({cur, b[i], 1'b0});
      cur = cur + 16'd1;
      data_n++;
    end
    if (data_n > 0) begin
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back({zp[k], cur[7:0], 1'b1});
        exp_q.push_back({zp[k] + 16'd1, cur[15:8], 1'b1});
      end
`ifdef PRG_AUTORUN_EN
      if (!cart) begin
        exp_q.push_back({16'h0277, 8'h52, 1'b1});
        exp_q.push_back({16'h0278, 8'h55, 1'b1});
        exp_q.push_back({16'h0279, 8'h4E, 1'b1});
        exp_q.push_back({16'h027A, 8'h0D, 1'b1});
        exp_q.push_back({16'h00C6, 8'h04, 1'b1});
      end
`endif
    end
    exp_force = cart ? 1 : 0;
  endtask

  always @(negedge clk_sys) begin
    wr_t e;
    cyc++;
    if (mem_wr === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_wr: got %h=%h, required no write", mem_addr, mem_data);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.a || mem_data !== e.d) begin
          n_err++;
          $display("FAIL wr_value: got %h=%h, required %h=%h", mem_addr, mem_data, e.a, e.d);
        end
        mem_obs[mem_addr] = mem_data;
        if (e.inj) begin
          inj_seen++;
          if (prev_inj_ok) begin
            n_vec++;
            if (cyc - prev_cyc != SP) begin
              n_err++;
              $display("FAIL inj_spacing: got %0d cycles, required %0d", cyc - prev_cyc, SP);
            end
          end
          prev_inj_ok = 1;
          prev_cyc = cyc;
        end else begin
          prev_inj_ok = 0;
        end
      end
    end
    if (force_reset === 1'b1) force_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send_bytes(input logic [7:0] b[$], input bit coincide);
    for (int i = 0; i < b.size(); i++) begin
      wr = 1'b1;
      addr = 16'(i);
      dout = b[i];
      if (coincide && i == b.size() - 1) downloading = 1'b0;
      tick();
      wr = 1'b0;
      tick();
    end
  endtask

  task automatic start_dl(input bit raw, input logic [7:0] idx);
    index = idx;
    raw_mode = raw;
    downloading = 1'b1;
    tick();
    tick();
  endtask

  task automatic wait_idle(input string name, input int inj0, input int inj_req);
    int k;
    k = 0;
    tick();
    while (busy && k < 300) begin
      tick();
      k++;
    end
    chk({name, "_busy_timeout"}, 32'(busy), 32'd0);
    repeat (4) tick();
    chk({name, "_missing_writes"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_force_pulses"}, 32'(force_cnt), 32'(exp_force));
    chk({name, "_inj_count"}, 32'(inj_seen - inj0), 32'(inj_req));
    force_cnt = 0;
  endtask

  logic [7:0] fb[$];
  int inj0, k;

  initial begin
    repeat (3) tick();
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_outputs", {mem_addr, mem_data, 5'd0, busy, force_reset, 1'b0}, 32'd0);
    reset = 1'b0;
    tick();

    // header load at $1001
    fb = '{8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC};
    build_model(fb, 0);
    inj0 = inj_seen;
    start_dl(0, 8'd1);
    send_bytes(fb, 0);
    downloading = 1'b0;
    wait_idle("hdr1001", inj0, INJ_FULL);
    chk("hdr1001_first", 32'(mem_obs[16'h1001]), 32'h00AA);
    chk("hdr1001_last", 32'(mem_obs[16'h1003]), 32'h00CC);
    chk("hdr1001_ptr", {16'd0, mem_obs[16'h00AF], mem_obs[16'h00AE]}, 32'h1004);
`ifdef PRG_AUTORUN_EN
    chk("hdr1001_kbcnt", 32'(mem_obs[16'h00C6]), 32'h0004);
`endif

    // raw cartridge at $A000
    fb = '{8'h11, 8'h22, 8'h33, 8'h44};
    build_model(fb, 1);
    inj0 = inj_seen;
    start_dl(1, 8'd2);
    send_bytes(fb, 0);
    downloading = 1'b0;
    wait_idle("raw_cart", inj0, 8);
    chk("raw_cart_data", 32'(mem_obs[16'hA003]), 32'h0044);
    chk("raw_cart_ptr", {16'd0, mem_obs[16'h0032], mem_obs[16'h0031]}, 32'hA004);

    // header only: nothing to write
    fb = '{8'h01, 8'h10};
    build_model(fb, 0);
    inj0 = inj_seen;
    start_dl(0, 8'd1);
    send_bytes(fb, 0);
    downloading = 1'b0;
    #2;
    chk("hdronly_busy_held", 32'(busy), 32'd1);
    @(posedge clk_sys);
    #2;
    chk("hdronly_busy_drop", 32'(busy), 32'd0);
    wait_idle("hdronly", inj0, 0);

    // address wrap, last byte coincident with end of download
    fb = '{8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03};
    build_model(fb, 0);
    inj0 = inj_seen;
    start_dl(0, 8'd3);
    send_bytes(fb, 1);
    wait_idle("wrap", inj0, INJ_FULL);
    chk("wrap_ffff", 32'(mem_obs[16'hFFFF]), 32'h0001);
    chk("wrap_ptr", {16'd0, mem_obs[16'h002E], mem_obs[16'h002D]}, 32'h0002);

    // reset during injection, right after the $30 write
    fb = '{8'h01, 8'h10, 8'hAA, 8'hBB, 8'hCC};
    build_model(fb, 0);
    inj0 = inj_seen;
    start_dl(0, 8'd1);
    send_bytes(fb, 0);
    downloading = 1'b0;
    k = 0;
    while (inj_seen - inj0 < 4 && k < 200) begin
      @(negedge clk_sys);
      #1;
      k++;
    end
    chk("rstinj_reached_30", 32'(inj_seen - inj0), 32'd4);
    reset = 1'b1;
    exp_q.delete();
    exp_force = 0;
    @(posedge clk_sys);
    #2;
    chk("rstinj_outputs", {mem_addr, mem_data, 5'd0, mem_wr, busy, force_reset}, 32'd0);
    chk("rstinj_30", 32'(mem_obs[16'h0030]), 32'h0010);
    tick();
    reset = 1'b0;
    tick();

    // ROM download is ignored
    fb = '{8'h01, 8'h10, 8'h55, 8'h66};
    inj0 = inj_seen;
    start_dl(0, 8'd0);
    chk("rom_not_busy", 32'(busy), 32'd0);
    send_bytes(fb, 0);
    downloading = 1'b0;
    wait_idle("rom", inj0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
